// File: rtl/mdiv_ctl.sv
// mdiv_ctl: cycle sequencer for the radix-4 divide datapath.
// Owns the working LO register and the architectural HI/LO commit.
module mdiv_ctl #(
   parameter int ITER_CYC = 16,
   parameter int CNT_W    = 4
) (
   input  logic        CLK,
   input  logic        RESET_D2_R,
   input  logic        DivStart_E,
   input  logic        DivIsU_E,
   input  logic        DivKill,
   input  logic        DivAck,
   input  logic        MtLo,
   input  logic        MtHi,
   input  logic [31:0] MtData,
   input  logic [39:0] DDATAHI,
   input  logic [39:0] DDATALO,
   output logic        DivDCyc0Go,
   output logic        DivDCyc0_R,
   output logic        DivDCycFirst_R,
   output logic        DivDCycLast_P,
   output logic        DivDCycLast_R,
   output logic        DivDCycZF_R_N,
   output logic        DivDCycFL_R_N,
   output logic        DIVxInProg,
   output logic        DivIsU_R,
   output logic [31:0] DivLo_R,
   output logic [31:0] LO_R,
   output logic [31:0] HI_R,
   output logic        DivBusy,
   output logic        DivRdy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CYC0,
      S_FIRST,
      S_ITER,
      S_LAST
   } state_e;

   state_e state_q, state_d;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             isu_q, isu_d;
   logic [31:0]      divlo_q, divlo_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      hi_q, hi_d;
   logic             rdy_q, rdy_d;
   logic             cyc0_q, cyc0_d;
   logic             first_q, first_d;
   logic             last_q, last_d;
   logic             zf_n_q, zf_n_d;
   logic             fl_n_q, fl_n_d;

   logic busy;
   logic accept;
   logic cnt_last;
   logic commit;
   logic lo_load;

   // Only the low word of the 40-bit datapath buses is architectural.
   logic unused_dd;
   assign unused_dd = ^{DDATAHI[39:32], DDATALO[39:32]};

   assign busy     = (state_q != S_IDLE);
   assign accept   = DivStart_E & ~busy & ~DivKill;
   assign cnt_last = (cnt_q == CNT_W'(ITER_CYC - 1));
   assign commit   = (state_q == S_LAST) & ~DivKill;
   assign lo_load  = (state_q == S_FIRST) |
                     (state_q == S_ITER) |
                     (state_q == S_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) state_d = S_CYC0;
         end
         S_CYC0: begin
            state_d = S_FIRST;
         end
         S_FIRST: begin
            state_d = S_ITER;
         end
         S_ITER: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_last) state_d = S_LAST;
         end
         S_LAST: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (busy && DivKill) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end
   end

   // Strobes are registered copies of the next state, so they are glitch-free.
   always_comb begin
      cyc0_d  = (state_d == S_CYC0);
      first_d = (state_d == S_FIRST);
      last_d  = (state_d == S_LAST);
      zf_n_d  = ~((state_d == S_CYC0) | (state_d == S_FIRST));
      fl_n_d  = (state_d == S_ITER);
   end

   always_comb begin
      isu_d   = isu_q;
      divlo_d = divlo_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      rdy_d   = rdy_q;
      if (accept) isu_d = DivIsU_E;
      if (lo_load) divlo_d = DDATALO[31:0];
      if (MtLo) begin
         lo_d = MtData;
      end else if (commit) begin
         lo_d = DDATALO[31:0];
      end
      if (MtHi) begin
         hi_d = MtData;
      end else if (commit) begin
         hi_d = DDATAHI[31:0];
      end
      if (DivAck || accept) rdy_d = 1'b0;
      if (commit) rdy_d = 1'b1;
   end

   always_ff @(posedge CLK) begin
      if (RESET_D2_R) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         isu_q   <= 1'b0;
         divlo_q <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         rdy_q   <= 1'b0;
         cyc0_q  <= 1'b0;
         first_q <= 1'b0;
         last_q  <= 1'b0;
         zf_n_q  <= 1'b1;
         fl_n_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         isu_q   <= isu_d;
         divlo_q <= divlo_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         rdy_q   <= rdy_d;
         cyc0_q  <= cyc0_d;
         first_q <= first_d;
         last_q  <= last_d;
         zf_n_q  <= zf_n_d;
         fl_n_q  <= fl_n_d;
      end
   end

   assign DivDCyc0Go     = accept;
   assign DivDCyc0_R     = cyc0_q;
   assign DivDCycFirst_R = first_q;
   assign DivDCycLast_P  = (state_q == S_ITER) & cnt_last;
   assign DivDCycLast_R  = last_q;
   assign DivDCycZF_R_N  = zf_n_q;
   assign DivDCycFL_R_N  = fl_n_q;
   assign DIVxInProg     = busy;
   assign DivBusy        = busy;
   assign DivIsU_R       = isu_q;
   assign DivLo_R        = divlo_q;
   assign LO_R           = lo_q;
   assign HI_R           = hi_q;
   assign DivRdy         = rdy_q;

endmodule

// File: tb/tb_mdiv_ctl.sv
// tb_mdiv_ctl: directed and random checks of the divide sequencer
// against a cycle-offset reference model with a divide datapath stub.
module tb_mdiv_ctl;

   logic        CLK;
   logic        RESET_D2_R;
   logic        DivStart_E;
   logic        DivIsU_E;
   logic        DivKill;
   logic        DivAck;
   logic        MtLo;
   logic        MtHi;
   logic [31:0] MtData;
   logic [39:0] DDATAHI;
   logic [39:0] DDATALO;
   logic        DivDCyc0Go;
   logic        DivDCyc0_R;
   logic        DivDCycFirst_R;
   logic        DivDCycLast_P;
   logic        DivDCycLast_R;
   logic        DivDCycZF_R_N;
   logic        DivDCycFL_R_N;
   logic        DIVxInProg;
   logic        DivIsU_R;
   logic [31:0] DivLo_R;
   logic [31:0] LO_R;
   logic [31:0] HI_R;
   logic        DivBusy;
   logic        DivRdy;

   mdiv_ctl #(.ITER_CYC(16), .CNT_W(4)) dut (
      .CLK            (CLK),
      .RESET_D2_R     (RESET_D2_R),
      .DivStart_E     (DivStart_E),
      .DivIsU_E       (DivIsU_E),
      .DivKill        (DivKill),
      .DivAck         (DivAck),
      .MtLo           (MtLo),
      .MtHi           (MtHi),
      .MtData         (MtData),
      .DDATAHI        (DDATAHI),
      .DDATALO        (DDATALO),
      .DivDCyc0Go     (DivDCyc0Go),
      .DivDCyc0_R     (DivDCyc0_R),
      .DivDCycFirst_R (DivDCycFirst_R),
      .DivDCycLast_P  (DivDCycLast_P),
      .DivDCycLast_R  (DivDCycLast_R),
      .DivDCycZF_R_N  (DivDCycZF_R_N),
      .DivDCycFL_R_N  (DivDCycFL_R_N),
      .DIVxInProg     (DIVxInProg),
      .DivIsU_R       (DivIsU_R),
      .DivLo_R        (DivLo_R),
      .LO_R           (LO_R),
      .HI_R           (HI_R),
      .DivBusy        (DivBusy),
      .DivRdy         (DivRdy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int cyc_n  = 0;
   int fl_cnt = 0;
   int go_cnt = 0;
   int go_at[$];
   bit chk_en = 1'b0;

   // Reference model: m_ph is the cycle offset since accept (0 = idle).
   int          m_ph  = 0;
   logic        m_isu = 1'b0;
   logic        m_rdy = 1'b0;
   logic        m_dlk = 1'b0;
   logic [31:0] m_divlo = '0;
   logic [31:0] m_lo = '0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_a = 32'd1;
   logic [31:0] m_b = 32'd1;
   logic        m_u = 1'b1;
   logic [31:0] op_a = 32'd1;
   logic [31:0] op_b = 32'd1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      logic [31:0] q;
      logic [31:0] r;
      logic        busy;
      logic        go;
      logic        commit;
      logic [10:0] es;
      logic [10:0] os;
      if (m_ph == 19) begin
         if (m_u) begin
            q = m_a / m_b;
            r = m_a % m_b;
         end else begin
            q = 32'($signed(m_a) / $signed(m_b));
            r = 32'($signed(m_a) % $signed(m_b));
         end
      end else begin
         q = $urandom;
         r = $urandom;
      end
      DDATALO = {8'($urandom), q};
      DDATAHI = {8'($urandom), r};
      #2;
      busy = (m_ph != 0);
      go   = DivStart_E && !busy && !DivKill;
      if (chk_en) begin
         es = {go, m_ph == 18, m_ph == 1, m_ph == 2, m_ph == 19,
               !(m_ph == 1 || m_ph == 2), (m_ph >= 3 && m_ph <= 18),
               busy, busy, m_isu, m_rdy};
         os = {DivDCyc0Go, DivDCycLast_P, DivDCyc0_R, DivDCycFirst_R,
               DivDCycLast_R, DivDCycZF_R_N, DivDCycFL_R_N,
               DIVxInProg, DivBusy, DivIsU_R, DivRdy};
         chk("strobes", 32'(os), 32'(es));
         chk("LO_R", LO_R, m_lo);
         chk("HI_R", HI_R, m_hi);
         if (m_dlk) chk("DivLo_R", DivLo_R, m_divlo);
      end
      if (DivDCycFL_R_N === 1'b1) fl_cnt++;
      if (DivDCyc0Go === 1'b1) begin
         go_cnt++;
         go_at.push_back(cyc_n);
      end
      @(posedge CLK);
      if (RESET_D2_R) begin
         m_ph = 0; m_isu = 1'b0; m_rdy = 1'b0;
         m_divlo = '0; m_dlk = 1'b1;
         m_lo = '0; m_hi = '0;
         chk_en = 1'b1;
      end else begin
         commit = (m_ph == 19) && !DivKill;
         if (busy && DivKill) m_dlk = 1'b0;
         else if (m_ph >= 2) begin
            m_divlo = DDATALO[31:0];
            m_dlk = 1'b1;
         end
         if (MtLo) m_lo = MtData;
         else if (commit) m_lo = DDATALO[31:0];
         if (MtHi) m_hi = MtData;
         else if (commit) m_hi = DDATAHI[31:0];
         if (commit) m_rdy = 1'b1;
         else if (DivAck || go) m_rdy = 1'b0;
         if (go) begin
            m_isu = DivIsU_E; m_u = DivIsU_E;
            m_a = op_a; m_b = op_b;
         end
         if (busy && DivKill) m_ph = 0;
         else if (go) m_ph = 1;
         else if (m_ph == 19) m_ph = 0;
         else if (busy) m_ph++;
      end
      cyc_n++;
      #1;
      DivStart_E = 1'b0; DivKill = 1'b0; DivAck = 1'b0;
      MtLo = 1'b0; MtHi = 1'b0; RESET_D2_R = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic start_div(input logic [31:0] a, input logic [31:0] b,
                            input logic u);
      op_a = a; op_b = b; DivIsU_E = u; DivStart_E = 1'b1;
   endtask

   initial begin
      int t0;
      logic [31:0] ra;
      logic [31:0] rb;
      RESET_D2_R = 1'b1; DivStart_E = 1'b0; DivIsU_E = 1'b0;
      DivKill = 1'b0; DivAck = 1'b0; MtLo = 1'b0; MtHi = 1'b0;
      MtData = '0; DDATAHI = '0; DDATALO = '0;
      cyc();
      chk("rst_lo", LO_R, 32'h0);
      chk("rst_hi", HI_R, 32'h0);
      chk("rst_rdy", 32'(DivRdy), 32'h0);
      chk("rst_zf_n", 32'(DivDCycZF_R_N), 32'h1);
      chk("rst_fl_n", 32'(DivDCycFL_R_N), 32'h0);
      chk("rst_busy", 32'(DivBusy), 32'h0);
      run(2);

      // Unsigned 100/7
      start_div(32'd100, 32'd7, 1'b1);
      cyc();
      chk("u_cyc0", 32'(DivDCyc0_R), 32'h1);
      run(19);
      chk("u_lo", LO_R, 32'h0000000E);
      chk("u_hi", HI_R, 32'h00000002);
      chk("u_rdy", 32'(DivRdy), 32'h1);
      chk("u_busy", 32'(DivBusy), 32'h0);
      DivAck = 1'b1;
      cyc();
      chk("u_ack", 32'(DivRdy), 32'h0);

      // Signed -7/2
      fl_cnt = 0;
      start_div(32'hFFFFFFF9, 32'd2, 1'b0);
      cyc();
      run(19);
      chk("s_lo", LO_R, 32'hFFFFFFFD);
      chk("s_hi", HI_R, 32'hFFFFFFFF);
      chk("s_isu", 32'(DivIsU_R), 32'h0);
      chk("s_fl_cycles", 32'(fl_cnt), 32'd16);

      // Kill mid-divide after LO preload
      MtLo = 1'b1; MtData = 32'h11111111; DivAck = 1'b1;
      cyc();
      chk("k_pre", LO_R, 32'h11111111);
      start_div(32'd12345, 32'd17, 1'b1);
      cyc();
      run(9);
      DivKill = 1'b1;
      cyc();
      chk("k_busy", 32'(DivBusy), 32'h0);
      chk("k_lo", LO_R, 32'h11111111);
      chk("k_rdy", 32'(DivRdy), 32'h0);
      start_div(32'd99999, 32'd3, 1'b1);
      cyc();
      chk("k_restart", 32'(DivDCyc0_R), 32'h1);
      run(19);
      chk("k_res_lo", LO_R, 32'd33333);

      // Start held for 30 cycles
      go_cnt = 0;
      go_at.delete();
      t0 = cyc_n;
      for (int i = 0; i < 30; i++) begin
         start_div(32'd500, 32'd9, 1'b1);
         cyc();
      end
      chk("h_count", 32'(go_cnt), 32'd2);
      chk("h_first", (go_at.size() > 0) ? 32'(go_at[0]) : 32'hFFFFFFFF,
          32'(t0));
      chk("h_gap", (go_at.size() > 1) ? 32'(go_at[1] - go_at[0])
          : 32'hFFFFFFFF, 32'd20);
      run(10);
      chk("h_lo", LO_R, 32'd55);

      // MtHi during LAST
      start_div(32'd100, 32'd7, 1'b1);
      cyc();
      run(18);
      chk("m_last", 32'(DivDCycLast_R), 32'h1);
      MtHi = 1'b1; MtData = 32'hCAFEF00D;
      cyc();
      chk("m_hi", HI_R, 32'hCAFEF00D);
      chk("m_lo", LO_R, 32'h0000000E);
      chk("m_rdy", 32'(DivRdy), 32'h1);
      DivAck = 1'b1;
      cyc();
      chk("m_ack", 32'(DivRdy), 32'h0);

      // Reset mid-divide
      start_div(32'd777, 32'd5, 1'b1);
      cyc();
      run(7);
      RESET_D2_R = 1'b1;
      cyc();
      chk("r_lo", LO_R, 32'h0);
      chk("r_hi", HI_R, 32'h0);
      chk("r_busy", 32'(DivBusy), 32'h0);
      chk("r_cyc0", 32'(DivDCyc0_R), 32'h0);
      chk("r_zf_n", 32'(DivDCycZF_R_N), 32'h1);
      run(15);
      chk("r_nocommit", 32'(DivRdy), 32'h0);
      start_div(32'd1000, 32'd10, 1'b1);
      cyc();
      run(19);
      chk("r_fresh_lo", LO_R, 32'd100);
      chk("r_fresh_rdy", 32'(DivRdy), 32'h1);

      // Random traffic
      for (int i = 0; i < 800; i++) begin
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 1) == 1) rb = 32'($urandom_range(1, 255));
         if (rb == 32'h0) rb = 32'd1;
         if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'd5;
         op_a = ra; op_b = rb;
         DivIsU_E   = 1'($urandom);
         DivStart_E = ($urandom_range(0, 99) < 30);
         DivKill    = ($urandom_range(0, 99) < 2);
         DivAck     = ($urandom_range(0, 99) < 20);
         MtLo       = ($urandom_range(0, 99) < 5);
         MtHi       = ($urandom_range(0, 99) < 5);
         MtData     = $urandom;
         RESET_D2_R = ($urandom_range(0, 499) == 0);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
